// File: rtl/mpsoc_noc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mpsoc_noc_pkg
//  Description : Shared NoC constants for the class-based mux/demux pair.
//  Revision    : 1.0 - initial release
// ============================================================================
package mpsoc_noc_pkg;

    // Default flit width used by the mux and its demultiplexer counterpart
    localparam int FLIT_WIDTH_DEF = 32;

    // Traffic-class field position inside a head flit
    localparam int CLASS_MSB = 26;
    localparam int CLASS_LSB = 24;

endpackage : mpsoc_noc_pkg
`default_nettype wire

// File: rtl/mpsoc_noc_arb_rr.sv
`default_nettype none
// ============================================================================
//  Module      : mpsoc_noc_arb_rr
//  Description : Combinational round-robin arbiter. Grants the first request
//                at or above the one-hot priority pointer, wrapping around.
//  Revision    : 1.0 - initial release
// ============================================================================
module mpsoc_noc_arb_rr #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    input  logic [N-1:0] prio,
    output logic [N-1:0] gnt,
    output logic [N-1:0] nxt_prio
);

    logic [2*N-1:0] w_dreq;
    logic [2*N-1:0] w_dgnt;

    // Doubling the request vector lets one subtraction find the first request
    // at/above prio; the upper copy covers the wrap-around case.
    assign w_dreq = {req, req};
    assign w_dgnt = w_dreq & ~(w_dreq - {{N{1'b0}}, prio});
    assign gnt    = w_dgnt[N-1:0] | w_dgnt[2*N-1:N];

    // Next priority sits just after the granted channel
    generate
        if (N == 1) begin : g_rot_single
            assign nxt_prio = gnt;
        end else begin : g_rot_multi
            assign nxt_prio = {gnt[N-2:0], gnt[N-1]};
        end
    endgenerate

endmodule : mpsoc_noc_arb_rr
`default_nettype wire

// File: rtl/mpsoc_noc_mux.sv
`default_nettype none
// ============================================================================
//  Module      : mpsoc_noc_mux
//  Description : Packet-level N:1 flit multiplexer. Round-robin arbitration
//                at packet boundaries; the output stays locked to a channel
//                from head acceptance until its tail transfers.
//  Revision    : 1.0 - initial release
// ============================================================================
module mpsoc_noc_mux
    import mpsoc_noc_pkg::*;
#(
    parameter int FLIT_WIDTH = FLIT_WIDTH_DEF,
    parameter int CHANNELS   = 7
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [CHANNELS-1:0][FLIT_WIDTH-1:0]  in_flit,
    input  logic [CHANNELS-1:0]                  in_last,
    input  logic [CHANNELS-1:0]                  in_valid,
    output logic [CHANNELS-1:0]                  in_ready,
    output logic [FLIT_WIDTH-1:0]                out_flit,
    output logic                                 out_last,
    output logic                                 out_valid,
    input  logic                                 out_ready
);

    logic [CHANNELS-1:0] active_q, active_d;
    logic [CHANNELS-1:0] prio_q,   prio_d;
    logic [CHANNELS-1:0] w_gnt;
    logic [CHANNELS-1:0] w_nxt_prio;
    logic [CHANNELS-1:0] w_sel;
    logic                w_xfer;

    mpsoc_noc_arb_rr #(
        .N (CHANNELS)
    ) u_arb (
        .req      (in_valid),
        .prio     (prio_q),
        .gnt      (w_gnt),
        .nxt_prio (w_nxt_prio)
    );

    // Channel select, AND-OR data mux and handshake outputs
    always_comb begin
        w_sel    = (active_q == '0) ? w_gnt : active_q;
        out_flit = '0;
        out_last = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            out_flit = out_flit | ({FLIT_WIDTH{w_sel[i]}} & in_flit[i]);
            out_last = out_last | (w_sel[i] & in_last[i]);
        end
        out_valid = |(w_sel & in_valid);
        // A single channel is a plain pass-through of downstream ready
        if (CHANNELS == 1) begin
            in_ready = {CHANNELS{out_ready}};
        end else begin
            in_ready = w_sel & {CHANNELS{out_ready}};
        end
        w_xfer = out_valid & out_ready;
    end

    // Lock/priority update: priority moves only on head acceptance
    always_comb begin
        active_d = active_q;
        prio_d   = prio_q;
        if (active_q == '0) begin
            if (w_xfer) begin
                prio_d = w_nxt_prio;
                if (!out_last) begin
                    active_d = w_sel;
                end
            end
        end else if (w_xfer && out_last) begin
            active_d = '0;
        end
    end

    // State registers; reset restarts arbitration from channel 0
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active_q <= '0;
            prio_q   <= {{(CHANNELS-1){1'b0}}, 1'b1};
        end else begin
            active_q <= active_d;
            prio_q   <= prio_d;
        end
    end

endmodule : mpsoc_noc_mux
`default_nettype wire

// File: tb/tb_mpsoc_noc_mux.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mpsoc_noc_mux
//  Description : Self-checking scoreboard bench for mpsoc_noc_mux.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mpsoc_noc_mux;

    localparam int FW = 32;
    localparam int CH = 7;
    localparam int DEPTH = 32;

    typedef struct packed {
        logic [2:0]    ch;
        logic [FW-1:0] flit;
        logic          last;
    } exp_t;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic [CH-1:0][FW-1:0]  in_flit;
    logic [CH-1:0]          in_last;
    logic [CH-1:0]          in_valid;
    logic [CH-1:0]          in_ready;
    logic [FW-1:0]          out_flit;
    logic                   out_last;
    logic                   out_valid;
    logic                   out_ready;

    // Per-channel source memories and control
    logic [FW:0]   src_mem [CH][DEPTH];
    int            src_wr  [CH];
    int            src_rd  [CH];
    logic [CH-1:0] bubble;
    logic          want_ready;
    exp_t          exp_q[$];

    int n_checks = 0;
    int n_err    = 0;

    mpsoc_noc_mux #(
        .FLIT_WIDTH (FW),
        .CHANNELS   (CH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_flit   (in_flit),
        .in_last   (in_last),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_flit  (out_flit),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load(input int ch, input logic [FW-1:0] d, input logic last);
        src_mem[ch][src_wr[ch]] = {last, d};
        src_wr[ch]++;
    endtask

    task automatic expect_xfer(input int ch, input logic [FW-1:0] d, input logic last);
        exp_t e;
        e.ch = 3'(ch); e.flit = d; e.last = last;
        exp_q.push_back(e);
    endtask

    // Load a flit into a source and push its expected output at the same time
    task automatic send(input int ch, input logic [FW-1:0] d, input logic last);
        load(ch, d, last);
        expect_xfer(ch, d, last);
    endtask

    task automatic drive_inputs();
        out_ready = want_ready;
        for (int i = 0; i < CH; i++) begin
            if (src_rd[i] < src_wr[i] && !bubble[i]) begin
                in_valid[i] = 1'b1;
                in_flit[i]  = src_mem[i][src_rd[i]][FW-1:0];
                in_last[i]  = src_mem[i][src_rd[i]][FW];
            end else begin
                in_valid[i] = 1'b0;
                in_flit[i]  = '0;
                in_last[i]  = 1'b0;
            end
        end
    endtask

    task automatic clear_sources();
        for (int i = 0; i < CH; i++) begin
            src_wr[i] = 0;
            src_rd[i] = 0;
        end
        bubble = '0;
        exp_q.delete();
    endtask

    // Observe any transfer and compare it against the scoreboard head
    task automatic monitor();
        exp_t e;
        int   oc;
        if (out_valid && out_ready) begin
            oc = -1;
            for (int i = 0; i < CH; i++) if (in_ready[i]) oc = i;
            chk("ready_onehot", 64'($onehot(in_ready)), 64'd1);
            if (exp_q.size() == 0) begin
                chk("unexpected_xfer", 64'(oc), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("xfer_ch",   64'(oc),       64'(e.ch));
                chk("xfer_flit", 64'(out_flit), 64'(e.flit));
                chk("xfer_last", 64'(out_last), 64'(e.last));
            end
            if (oc >= 0) src_rd[oc]++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drive_inputs();
        @(negedge clk);
        monitor();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_sources();
        drive_inputs();
        @(negedge clk);
        chk("rst_active", 64'(dut.active_q), 64'd0);
        chk("rst_prio",   64'(dut.prio_q),   64'h01);
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive_inputs();
        @(negedge clk);
    endtask

    initial begin
        want_ready = 1'b1;
        clear_sources();
        drive_inputs();

        // 1: reset and idle
        repeat (3) begin
            @(negedge clk);
            chk("t1_rst_valid", 64'(out_valid), 64'd0);
            chk("t1_rst_ready", 64'(in_ready),  64'd0);
            chk("t1_rst_last",  64'(out_last),  64'd0);
            chk("t1_rst_prio",  64'(dut.prio_q), 64'h01);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (3) begin
            tick();
            chk("t1_idle_valid", 64'(out_valid), 64'd0);
            chk("t1_idle_ready", 64'(in_ready),  64'd0);
        end
        chk("t1_prio", 64'(dut.prio_q), 64'h01);

        // 2: three-flit packet on channel 2
        send(2, 32'hA, 1'b0);
        send(2, 32'hB, 1'b0);
        send(2, 32'hC, 1'b1);
        tick(); chk("t2_ready_a", 64'(in_ready), 64'h04);
        tick(); chk("t2_ready_b", 64'(in_ready), 64'h04);
        chk("t2_active", 64'(dut.active_q), 64'h04);
        tick(); chk("t2_ready_c", 64'(in_ready), 64'h04);
        tick(); chk("t2_unlock", 64'(dut.active_q), 64'd0);
        chk("t2_drain", 64'(exp_q.size()), 64'd0);

        // 3: ch1 and ch4 contend, ch1 wins, no interleave
        do_reset();
        load(1, 32'h1000_0001, 1'b0); load(1, 32'h1000_0002, 1'b1);
        load(4, 32'h4000_0001, 1'b0); load(4, 32'h4000_0002, 1'b1);
        expect_xfer(1, 32'h1000_0001, 1'b0); expect_xfer(1, 32'h1000_0002, 1'b1);
        expect_xfer(4, 32'h4000_0001, 1'b0); expect_xfer(4, 32'h4000_0002, 1'b1);
        repeat (5) tick();
        chk("t3_drain", 64'(exp_q.size()), 64'd0);

        // 4: lock holds across a bubble while ch0 waits
        do_reset();
        send(3, 32'h3000_00A0, 1'b0);
        tick();
        load(3, 32'h3000_00A1, 1'b0);
        load(3, 32'h3000_00A2, 1'b1);
        load(0, 32'h0000_00F0, 1'b1);
        bubble[3] = 1'b1;
        repeat (2) begin
            tick();
            chk("t4_bubble_valid", 64'(out_valid),   64'd0);
            chk("t4_bubble_ch0",   64'(in_ready[0]), 64'd0);
            chk("t4_bubble_lock",  64'(dut.active_q), 64'h08);
        end
        bubble[3] = 1'b0;
        expect_xfer(3, 32'h3000_00A1, 1'b0);
        expect_xfer(3, 32'h3000_00A2, 1'b1);
        expect_xfer(0, 32'h0000_00F0, 1'b1);
        tick(); tick();
        tick(); chk("t4_ch0_ready", 64'(in_ready), 64'h01);
        tick();
        chk("t4_drain", 64'(exp_q.size()), 64'd0);

        // 5: backpressure on a head flit
        do_reset();
        want_ready = 1'b0;
        send(5, 32'hDEADBEEF, 1'b0);
        send(5, 32'h0000_1234, 1'b1);
        repeat (4) begin
            tick();
            chk("t5_hold_flit",  64'(out_flit),  64'hDEADBEEF);
            chk("t5_hold_valid", 64'(out_valid), 64'd1);
            chk("t5_hold_ready", 64'(in_ready),  64'd0);
            chk("t5_hold_act",   64'(dut.active_q), 64'd0);
        end
        want_ready = 1'b1;
        tick();
        tick(); chk("t5_locked", 64'(dut.active_q), 64'h20);
        tick(); chk("t5_unlock", 64'(dut.active_q), 64'd0);
        chk("t5_drain", 64'(exp_q.size()), 64'd0);

        // 6: fairness with all channels busy, then reset mid-stream
        do_reset();
        for (int k = 0; k < 3; k++)
            for (int c = 0; c < CH; c++)
                send(c, FW'((c << 8) | k), 1'b1);
        repeat (10) tick();
        chk("t6_no_lock", 64'(dut.active_q), 64'd0);
        do_reset();
        for (int c = 0; c < CH; c++) send(c, FW'(32'hF000_0000 | c), 1'b1);
        repeat (7) tick();
        chk("t6_drain", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_mpsoc_noc_mux
`default_nettype wire
